// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared ALU control definitions used by the decoder, the hazard unit and the
// write-back sequencer.
//   - ALU op encodings (3 bits)
//   - write-back sequencer state type {IDLE, SECOND}
//   - is_swap(op): 1 when the op needs two register-file writes
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

  localparam int unsigned ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_MOVE = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_SWAP = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'b101;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } wb_state_t;

  // Only the exact SWAP encoding issues a second write; 3'b101..3'b111 do not.
  function automatic logic is_swap(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_SWAP);
  endfunction

endpackage

// File: rtl/swap_wb_sequencer.sv
// -----------------------------------------------------------------------------
// swap_wb_sequencer
// Serializes ALU results into the single-write-port register file. Ordinary
// ops produce one registered write; SWAP produces two writes on consecutive
// cycles (low half to RdA, then high half to RdB) while Stall holds the
// upstream pipeline for the one cycle spent in SECOND.
//
// Parameters:
//   DATA_W  register / ALU operand width (result bus is 2*DATA_W)
//   REG_AW  register-file address width
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   InValid     in   instruction presented this cycle
//   RegWrite    in   presented instruction writes the register file
//   Flush       in   kill the presented instruction
//   ALUControl  in   ALU op of the presented instruction
//   Result      in   {Result2, Result1}
//   RdA         in   destination of the low half
//   RdB         in   destination of the high half (SWAP only)
//   WrEn        out  register-file write enable (registered)
//   WrAddr      out  register-file write address (registered)
//   WrData      out  register-file write data (registered)
//   Stall       out  upstream must hold; decoded from state == SECOND
//   SwapCount   out  retired SWAP count, saturating (registered)
// -----------------------------------------------------------------------------
module swap_wb_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  InValid,
  input  logic                  RegWrite,
  input  logic                  Flush,
  input  logic [2:0]            ALUControl,
  input  logic [2*DATA_W-1:0]   Result,
  input  logic [REG_AW-1:0]     RdA,
  input  logic [REG_AW-1:0]     RdB,
  output logic                  WrEn,
  output logic [REG_AW-1:0]     WrAddr,
  output logic [DATA_W-1:0]     WrData,
  output logic                  Stall,
  output logic [15:0]           SwapCount
);

  wb_state_t             state_r;
  logic                  wr_en_r;
  logic [REG_AW-1:0]     wr_addr_r;
  logic [DATA_W-1:0]     wr_data_r;
  logic [REG_AW-1:0]     hold_addr_r;
  logic [DATA_W-1:0]     hold_data_r;
  logic [15:0]           swap_count_r;
  logic                  accept_s;

  // Accept decode: a live, writing, unflushed instruction while not mid-SWAP.
  always_comb begin
    accept_s = 1'b0;
    if (InValid && RegWrite && !Flush && (state_r == IDLE)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Sequencer FSM with registered write port, holding register and SWAP counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= {REG_AW{1'b0}};
      wr_data_r    <= {DATA_W{1'b0}};
      hold_addr_r  <= {REG_AW{1'b0}};
      hold_data_r  <= {DATA_W{1'b0}};
      swap_count_r <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= RdA;
            wr_data_r <= Result[DATA_W-1:0];
            if (is_swap(ALUControl)) begin
              hold_addr_r <= RdB;
              hold_data_r <= Result[2*DATA_W-1:DATA_W];
              state_r     <= SECOND;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            // No write: address and data keep their last values.
            wr_en_r <= 1'b0;
            state_r <= IDLE;
          end
        end
        SECOND: begin
          // The first write has committed, so the second one is never
          // cancelled by Flush; all inputs are ignored here.
          wr_en_r   <= 1'b1;
          wr_addr_r <= hold_addr_r;
          wr_data_r <= hold_data_r;
          if (swap_count_r != 16'hFFFF) begin
            swap_count_r <= swap_count_r + 16'd1;
          end else begin
            swap_count_r <= swap_count_r;
          end
          state_r <= IDLE;
        end
        default: begin
          wr_en_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign WrEn      = wr_en_r;
  assign WrAddr    = wr_addr_r;
  assign WrData    = wr_data_r;
  assign SwapCount = swap_count_r;
  // Stall comes straight from the state register so it tracks reset without a clock.
  assign Stall     = (state_r == SECOND);

endmodule

// File: tb/tb_swap_wb_sequencer.sv
// -----------------------------------------------------------------------------
// tb_swap_wb_sequencer
// Directed bench for swap_wb_sequencer. Each tick() first decides from the
// current inputs what the sequencer must do at the coming edge, pushes the
// expected register-file writes onto a queue, then after the edge pops and
// compares whatever write the DUT produced.
// -----------------------------------------------------------------------------
module tb_swap_wb_sequencer;
  import alu_ctrl_pkg::*;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_AW = 4;

  logic                clk;
  logic                reset;
  logic                InValid;
  logic                RegWrite;
  logic                Flush;
  logic [2:0]          ALUControl;
  logic [2*DATA_W-1:0] Result;
  logic [REG_AW-1:0]   RdA;
  logic [REG_AW-1:0]   RdB;
  logic                WrEn;
  logic [REG_AW-1:0]   WrAddr;
  logic [DATA_W-1:0]   WrData;
  logic                Stall;
  logic [15:0]         SwapCount;

  swap_wb_sequencer #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .InValid    (InValid),
    .RegWrite   (RegWrite),
    .Flush      (Flush),
    .ALUControl (ALUControl),
    .Result     (Result),
    .RdA        (RdA),
    .RdB        (RdB),
    .WrEn       (WrEn),
    .WrAddr     (WrAddr),
    .WrData     (WrData),
    .Stall      (Stall),
    .SwapCount  (SwapCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard entry: {addr, data}
  logic [REG_AW+DATA_W-1:0] exp_q[$];

  int          checks;
  int          errors;
  logic        m_second;
  logic [15:0] m_count;
  logic [REG_AW-1:0] last_addr;
  logic [DATA_W-1:0] last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic fl, input logic [2:0] op,
                       input logic [31:0] res, input logic [3:0] a, input logic [3:0] b);
    InValid    = v;
    RegWrite   = rw;
    Flush      = fl;
    ALUControl = op;
    Result     = res;
    RdA        = a;
    RdB        = b;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, ALU_ADD, 32'h0000_0000, 4'd0, 4'd0);
  endtask

  // One clock: predict from the current inputs, clock, then compare.
  task automatic tick(input string tag);
    logic        second_n;
    logic [15:0] count_n;
    logic [REG_AW+DATA_W-1:0] e;
    second_n = 1'b0;
    count_n  = m_count;
    if (reset) begin
      exp_q.delete();
      count_n   = 16'd0;
      last_addr = '0;
      last_data = '0;
    end else if (m_second) begin
      count_n = (m_count == 16'hFFFF) ? m_count : m_count + 16'd1;
    end else if (InValid && RegWrite && !Flush) begin
      exp_q.push_back({RdA, Result[15:0]});
      if (ALUControl == 3'b011) begin
        exp_q.push_back({RdB, Result[31:16]});
        second_n = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    m_second = second_n;
    m_count  = count_n;
    chk({tag, ".stall"}, {31'd0, Stall}, {31'd0, m_second});
    chk({tag, ".swapcount"}, {16'd0, SwapCount}, {16'd0, m_count});
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      last_addr = e[REG_AW+DATA_W-1:DATA_W];
      last_data = e[DATA_W-1:0];
      chk({tag, ".wren"}, {31'd0, WrEn}, 32'd1);
    end else begin
      chk({tag, ".wren"}, {31'd0, WrEn}, 32'd0);
    end
    chk({tag, ".wraddr"}, {28'd0, WrAddr}, {28'd0, last_addr});
    chk({tag, ".wrdata"}, {16'd0, WrData}, {16'd0, last_data});
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    m_second  = 1'b0;
    m_count   = 16'd0;
    last_addr = '0;
    last_data = '0;
    reset     = 1'b1;
    idle();
    tick("rst0");
    tick("rst1");
    reset = 1'b0;
    tick("after_rst");

    // Plain ADD
    drive(1'b1, 1'b1, 1'b0, ALU_ADD, 32'h0000_1234, 4'd3, 4'd0);
    tick("add");
    idle();
    tick("add_hold");

    // SWAP alone
    drive(1'b1, 1'b1, 1'b0, ALU_SWAP, 32'hAAAA_5555, 4'd1, 4'd2);
    tick("swap_w1");
    idle();
    tick("swap_w2");
    tick("swap_idle");

    // SWAP then MOVE held through the stall
    drive(1'b1, 1'b1, 1'b0, ALU_SWAP, 32'hAAAA_5555, 4'd1, 4'd2);
    tick("sm_w1");
    drive(1'b1, 1'b1, 1'b0, ALU_MOVE, 32'h0000_0007, 4'd4, 4'd0);
    tick("sm_w2");
    tick("sm_move");
    idle();
    tick("sm_idle");

    // Flushed SUB: no write
    drive(1'b1, 1'b1, 1'b1, ALU_SUB, 32'h0000_BEEF, 4'd7, 4'd0);
    tick("flush_sub");
    // SWAP, then Flush during SECOND is ignored
    drive(1'b1, 1'b1, 1'b0, ALU_SWAP, 32'h1111_2222, 4'd8, 4'd9);
    tick("fswap_w1");
    drive(1'b1, 1'b1, 1'b1, ALU_ADD, 32'h0000_3333, 4'd10, 4'd0);
    tick("fswap_w2");
    idle();
    tick("fswap_idle");

    // SWAP with RegWrite=0: no write, no stall
    drive(1'b1, 1'b0, 1'b0, ALU_SWAP, 32'h4444_5555, 4'd11, 4'd12);
    tick("nowr_swap");

    // Reset asserted while in SECOND
    drive(1'b1, 1'b1, 1'b0, ALU_SWAP, 32'hCAFE_F00D, 4'd1, 4'd2);
    tick("rswap_w1");
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst.wren",   {31'd0, WrEn},      32'd0);
    chk("async_rst.wraddr", {28'd0, WrAddr},    32'd0);
    chk("async_rst.wrdata", {16'd0, WrData},    32'd0);
    chk("async_rst.stall",  {31'd0, Stall},     32'd0);
    chk("async_rst.count",  {16'd0, SwapCount}, 32'd0);
    m_second = 1'b0;
    tick("rst_hold");
    reset = 1'b0;
    tick("rst_release");

    // ADD after reset
    drive(1'b1, 1'b1, 1'b0, ALU_ADD, 32'h0000_0BEE, 4'd5, 4'd0);
    tick("add2");

    // SWAP with RdA == RdB
    drive(1'b1, 1'b1, 1'b0, ALU_SWAP, 32'h00FF_FF00, 4'd6, 4'd6);
    tick("same_w1");
    idle();
    tick("same_w2");

    // Op 3'b111 is not SWAP, back-to-back with an ADD
    drive(1'b1, 1'b1, 1'b0, 3'b111, 32'hFFFF_0001, 4'd10, 4'd13);
    tick("op7");
    drive(1'b1, 1'b1, 1'b0, ALU_ADD, 32'h0000_00AB, 4'd14, 4'd0);
    tick("b2b_add");

    // Back-to-back SWAPs: Stall every other cycle
    drive(1'b1, 1'b1, 1'b0, ALU_SWAP, 32'h0102_0304, 4'd1, 4'd2);
    tick("bb_a1");
    drive(1'b1, 1'b1, 1'b0, ALU_SWAP, 32'h0506_0708, 4'd3, 4'd4);
    tick("bb_a2");
    tick("bb_b1");
    idle();
    tick("bb_b2");
    tick("bb_idle");

    chk("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
